// File: rtl/npc_ctrl_pkg.sv
// Shared control definitions for the NPC multi-cycle sequencer: states, RV32 major opcodes
// and the ebreak encoding.
package npc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_e;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   function automatic logic opc_legal(input logic [6:0] opc);
      case (opc)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
         OP_LOAD, OP_STORE, OP_IMM, OP_OP: opc_legal = 1'b1;
         default:                          opc_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/npc_wait_timer.sv
// Saturating wait counter for bus handshakes; expired is high while the count equals limit.
module npc_wait_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && (count_q != limit)) begin
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == limit);

endmodule

// File: rtl/npc_stage_seq.sv
// Multi-cycle instruction sequencer: owns the PC, fetches one word at a time and steps it
// through DECODE/EXEC/MEM/WB; halts on ebreak, illegal opcode or handshake timeout.
module npc_stage_seq
   import npc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [7:0]  TIMEOUT  = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifetch_req,
   output logic [31:0] ifetch_addr,
   input  logic        ifetch_ack,
   input  logic [31:0] ifetch_data,
   output logic [31:0] inst,
   output logic [31:0] pc,
   input  logic [31:0] next_pc,
   output logic        lsu_req,
   input  logic        lsu_ack,
   output logic        exec_en,
   output logic        rf_wen,
   output logic        halt,
   output logic        err
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        err_q, err_d;
   logic        tmr_clr, tmr_inc, tmr_expired;
   logic [6:0]  opc;

   assign opc = inst_q[6:0];

   npc_wait_timer #(.W(8)) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmr_clr),
      .inc     (tmr_inc),
      .limit   (TIMEOUT),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      err_d   = err_q;
      tmr_inc = 1'b0;
      case (state_q)
         ST_IDLE:   state_d = ST_FETCH;
         ST_FETCH: begin
            // ack takes priority over an expiring timer in the same cycle
            if (ifetch_ack) begin
               inst_d  = ifetch_data;
               state_d = ST_DECODE;
            end else if (tmr_expired) begin
               err_d   = 1'b1;
               state_d = ST_HALT;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         ST_DECODE: begin
            if (inst_q == INST_EBREAK) begin
               state_d = ST_HALT;
            end else if (opc_legal(opc)) begin
               state_d = ST_EXEC;
            end else begin
               err_d   = 1'b1;
               state_d = ST_HALT;
            end
         end
         ST_EXEC:   state_d = ((opc == OP_LOAD) || (opc == OP_STORE)) ? ST_MEM : ST_WB;
         ST_MEM: begin
            if (lsu_ack) begin
               state_d = ST_WB;
            end else if (tmr_expired) begin
               err_d   = 1'b1;
               state_d = ST_HALT;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         ST_WB: begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
         end
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_IDLE;
      endcase
      // Any state change restarts the wait count, so FETCH/MEM always enter at zero.
      tmr_clr = (state_d != state_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
      end
   end

   assign ifetch_req  = (state_q == ST_FETCH);
   assign ifetch_addr = pc_q;
   assign inst        = inst_q;
   assign pc          = pc_q;
   assign lsu_req     = (state_q == ST_MEM);
   assign exec_en     = (state_q == ST_EXEC);
   assign rf_wen      = (state_q == ST_WB) && (opc != OP_BRANCH) && (opc != OP_STORE)
                        && (inst_q[11:7] != 5'd0);
   assign halt        = (state_q == ST_HALT);
   assign err         = err_q;

endmodule

// File: tb/tb_npc_stage_seq.sv
// Directed self-checking bench for npc_stage_seq (TIMEOUT overridden to 4).
module tb_npc_stage_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifetch_req;
   logic [31:0] ifetch_addr;
   logic        ifetch_ack;
   logic [31:0] ifetch_data;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        lsu_req;
   logic        lsu_ack;
   logic        exec_en;
   logic        rf_wen;
   logic        halt;
   logic        err;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   npc_stage_seq #(.RESET_PC(32'h8000_0000), .TIMEOUT(8'd4)) dut (
      .clk         (clk),
      .rst         (rst),
      .ifetch_req  (ifetch_req),
      .ifetch_addr (ifetch_addr),
      .ifetch_ack  (ifetch_ack),
      .ifetch_data (ifetch_data),
      .inst        (inst),
      .pc          (pc),
      .next_pc     (next_pc),
      .lsu_req     (lsu_req),
      .lsu_ack     (lsu_ack),
      .exec_en     (exec_en),
      .rf_wen      (rf_wen),
      .halt        (halt),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Full instruction with same-cycle fetch ack; starts in FETCH, ends in the next FETCH.
   task automatic run_insn(input logic [31:0] w, input logic [31:0] npc, input bit is_mem,
                           input int unsigned lsu_delay, input logic exp_wen);
      int unsigned cnt;
      check("fetch_req", {31'd0, ifetch_req}, 32'd1);
      next_pc     = npc;
      ifetch_ack  = 1'b1;
      ifetch_data = w;
      tick();
      ifetch_ack  = 1'b0;
      check("inst_latch", inst, w);
      check("decode_exec_en", {31'd0, exec_en}, 32'd0);
      tick();
      check("exec_en", {31'd0, exec_en}, 32'd1);
      tick();
      if (is_mem) begin
         cnt = 0;
         while (lsu_req && cnt < 32) begin
            lsu_ack = (cnt == lsu_delay);
            tick();
            cnt++;
         end
         lsu_ack = 1'b0;
         check("lsu_req_cycles", cnt, lsu_delay + 1);
      end else begin
         check("no_lsu_req", {31'd0, lsu_req}, 32'd0);
      end
      check("wb_rf_wen", {31'd0, rf_wen}, {31'd0, exp_wen});
      tick();
      check("pc_next", pc, npc);
      check("refetch_req", {31'd0, ifetch_req}, 32'd1);
      check("rf_wen_drop", {31'd0, rf_wen}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; ifetch_ack = 1'b0; ifetch_data = '0; next_pc = '0; lsu_ack = 1'b0;
      repeat (3) tick();
      check("rst_pc", pc, 32'h8000_0000);
      check("rst_ifetch_req", {31'd0, ifetch_req}, 32'd0);
      check("rst_lsu_req", {31'd0, lsu_req}, 32'd0);
      check("rst_exec_en", {31'd0, exec_en}, 32'd0);
      check("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
      check("rst_halt", {31'd0, halt}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_inst", inst, 32'd0);
      rst = 1'b0;
      check("idle_no_req", {31'd0, ifetch_req}, 32'd0);
      tick();
      check("first_fetch_req", {31'd0, ifetch_req}, 32'd1);
      check("first_fetch_addr", ifetch_addr, 32'h8000_0000);

      run_insn(32'h0050_0093, 32'h8000_0004, 1'b0, 0, 1'b1);  // addi x1,x0,5
      check("fetch_addr_pc", ifetch_addr, 32'h8000_0004);
      run_insn(32'h0000_a103, 32'h8000_0008, 1'b1, 3, 1'b1);  // lw x2
      run_insn(32'h0020_a023, 32'h8000_000c, 1'b1, 0, 1'b0);  // sw
      run_insn(32'h0000_0463, 32'h8000_0100, 1'b0, 0, 1'b0);  // beq taken
      run_insn(32'h0000_0013, 32'hffff_fffc, 1'b0, 0, 1'b0);  // addi x0 (nop)

      // ebreak: clean halt, later acks ignored
      ifetch_ack = 1'b1; ifetch_data = 32'h0010_0073;
      tick();
      ifetch_ack = 1'b0;
      check("ebreak_decode_halt", {31'd0, halt}, 32'd0);
      tick();
      check("ebreak_halt", {31'd0, halt}, 32'd1);
      check("ebreak_err", {31'd0, err}, 32'd0);
      check("ebreak_no_exec", {31'd0, exec_en}, 32'd0);
      ifetch_ack = 1'b1; lsu_ack = 1'b1; ifetch_data = 32'h0050_0093;
      repeat (3) tick();
      ifetch_ack = 1'b0; lsu_ack = 1'b0;
      check("halt_sticky", {31'd0, halt}, 32'd1);
      check("halt_pc_frozen", pc, 32'hffff_fffc);
      check("halt_inst_frozen", inst, 32'h0010_0073);
      check("halt_no_req", {30'd0, ifetch_req, lsu_req}, 32'd0);
      rst = 1'b1;
      tick();
      check("rst_clears_halt", {31'd0, halt}, 32'd0);
      check("rst_reloads_pc", pc, 32'h8000_0000);
      rst = 1'b0;
      tick();

      // illegal opcodes: 0x7F and a non-ebreak SYSTEM encoding
      ifetch_ack = 1'b1; ifetch_data = 32'h0000_007f;
      tick();
      ifetch_ack = 1'b0;
      tick();
      check("illegal_halt", {31'd0, halt}, 32'd1);
      check("illegal_err", {31'd0, err}, 32'd1);
      do_reset();
      check("rst_clears_err", {31'd0, err}, 32'd0);
      ifetch_ack = 1'b1; ifetch_data = 32'h0000_0073;
      tick();
      ifetch_ack = 1'b0;
      tick();
      check("ecall_err", {30'd0, halt, err}, 32'd3);

      // fetch timeout: entry cycle at 0, four idle cycles reach 4, fifth halts
      do_reset();
      repeat (4) tick();
      check("timeout_still_fetch", {30'd0, ifetch_req, halt}, 32'd2);
      tick();
      check("timeout_halt", {31'd0, halt}, 32'd1);
      check("timeout_err", {31'd0, err}, 32'd1);

      // ack on the expiring cycle wins
      do_reset();
      repeat (4) tick();
      ifetch_ack = 1'b1; ifetch_data = 32'h0000_a103;
      tick();
      ifetch_ack = 1'b0;
      check("late_ack_no_halt", {31'd0, halt}, 32'd0);
      check("late_ack_inst", inst, 32'h0000_a103);
      tick();
      check("late_ack_exec", {31'd0, exec_en}, 32'd1);
      tick();
      check("mem_entered", {31'd0, lsu_req}, 32'd1);

      // reset in MEM aborts cleanly
      rst = 1'b1;
      tick();
      check("mem_rst_lsu_drop", {31'd0, lsu_req}, 32'd0);
      check("mem_rst_pc", pc, 32'h8000_0000);
      rst = 1'b0;
      tick();
      check("restart_fetch", {31'd0, ifetch_req}, 32'd1);
      check("restart_addr", ifetch_addr, 32'h8000_0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
